timer_cmd_tx: RTL and testbench

- Command transmitter for the serial-triggered countdown timer `top_fsm`.
- The timer waits for the start pattern 1101 on `data`, then shifts in a 4-bit delay MSB-first, then counts (delay+1)*1000 cycles. It holds `done` until `ack`.
- This block generates that serial stream from a parallel request, waits for `done`, and returns the handshake `ack`.
- Sits beside `top_fsm` on the same clock; `data`/`ack` are outputs here and inputs there; `counting`/`done` are inputs here.

---
 rtl/timer_cmd_tx.sv | 112 +++++++++++
 tb/tb_timer_cmd_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx: serialises start pattern + 4-bit delay to top_fsm, waits for done, returns ack.
// Optional WAIT watchdog with sticky err when TIMER_TX_TIMEOUT_EN is defined.
module timer_cmd_tx #(
    parameter logic [3:0] PATTERN        = 4'b1101,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter int         TO_W           = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] delay,
    input  logic       counting,
    input  logic       done,
    output logic       data,
    output logic       ack,
    output logic       busy,
    output logic       busy_cnt,
    output logic       cmd_done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, PAT, DLY, WAIT, ACK} state_t;

    state_t     r_state;
    logic [1:0] r_bit;
    logic [3:0] r_dreg;
    logic [1:0] w_idx;

    // r_bit counts bits already on the wire, so the next one is index 2-r_bit
    assign w_idx = 2'd2 - r_bit;

    if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TO_W)) begin : g_bad_cfg
        $error("timer_cmd_tx: TO_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef TIMER_TX_TIMEOUT_EN
    logic [TO_W-1:0] r_to;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_bit    <= 2'd0;
            r_dreg   <= 4'd0;
            data     <= 1'b0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            busy_cnt <= 1'b0;
            cmd_done <= 1'b0;
`ifdef TIMER_TX_TIMEOUT_EN
            r_to     <= '0;
            err      <= 1'b0;
`endif
        end else begin
            data     <= 1'b0;
            ack      <= 1'b0;
            cmd_done <= 1'b0;
            busy_cnt <= counting & busy;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= PAT;
                    r_dreg  <= delay;
                    r_bit   <= 2'd0;
                    busy    <= 1'b1;
                    data    <= PATTERN[3];
                end
                PAT: begin
                    r_bit <= r_bit + 2'd1;
                    if (r_bit == 2'd3) begin
                        r_state <= DLY;
                        data    <= r_dreg[3];
                    end else
                        data <= PATTERN[w_idx];
                end
                DLY: begin
                    r_bit <= r_bit + 2'd1;
                    if (r_bit == 2'd3) begin
                        r_state <= WAIT;
`ifdef TIMER_TX_TIMEOUT_EN
                        r_to    <= '0;
`endif
                    end else
                        data <= r_dreg[w_idx];
                end
                WAIT: begin
                    if (done) begin
                        r_state <= ACK;
                        ack     <= 1'b1;
                    end
`ifdef TIMER_TX_TIMEOUT_EN
                    else if (r_to == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else
                        r_to <= r_to + 1'b1;
`endif
                end
                ACK: begin
                    r_state  <= IDLE;
                    busy     <= 1'b0;
                    cmd_done <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_cmd_tx.sv
// tb_timer_cmd_tx: randomized scoreboard bench for timer_cmd_tx with a stand-in timer responder.
module tb_timer_cmd_tx;
    localparam logic [3:0] PAT = 4'b1101;
    localparam int TO = 50;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, counting = 1'b0;
    logic r_done = 1'b0, s_done = 1'b0, done;
    logic [3:0] delay = 4'd0;
    logic data, ack, busy, busy_cnt, cmd_done, err;
    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    int scale = 0;
    bit mute = 1'b0;

    assign done = r_done | s_done;
    always #5 clk = ~clk;

    timer_cmd_tx #(.PATTERN(PAT), .TIMEOUT_CYCLES(TO), .TO_W(15)) dut (
        .clk(clk), .reset(reset), .start(start), .delay(delay), .counting(counting), .done(done),
        .data(data), .ack(ack), .busy(busy), .busy_cnt(busy_cnt), .cmd_done(cmd_done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ph 0 idle, 1..8 = n-th serial bit, 9 waiting for done, 10 ack cycle
    int ph = 0, wcnt = 0;
    logic [7:0] word = 8'd0;
    logic m_err = 1'b0, m_cmd = 1'b0, m_bcnt = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph = 0; wcnt = 0; m_err = 1'b0; m_cmd = 1'b0; m_bcnt = 1'b0;
        end else begin
            m_bcnt = counting & (ph != 0);
            m_cmd = (ph == 10);
            if (ph == 0) begin
                if (start) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_empty", 32'd1, 32'd0);
                        word = {PAT, delay};
                    end else
                        word = exp_q.pop_front();
                    ph = 1;
                end
            end else if (ph <= 8) begin
                ph = ph + 1;
                wcnt = 0;
            end else if (ph == 9) begin
                if (done) ph = 10;
`ifdef TIMER_TX_TIMEOUT_EN
                else if (wcnt == TO - 1) begin ph = 0; m_err = 1'b1; end
                else wcnt = wcnt + 1;
`endif
            end else
                ph = 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("data", data, (ph >= 1 && ph <= 8) ? word[8-ph] : 1'b0);
            check("busy", busy, ph != 0);
            check("ack", ack, ph == 10);
            check("cmd_done", cmd_done, m_cmd);
            check("busy_cnt", busy_cnt, m_bcnt);
            check("err", err, m_err);
        end
    end

    // Stand-in for top_fsm: decodes the stream, counts, raises done until ack, plus stray done pulses
    initial begin
        logic [7:0] win;
        int st, cnt;
        win = 8'd0; st = 0; cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                win = 8'd0; st = 0; r_done = 1'b0; counting = 1'b0;
            end else if (st == 0) begin
                win = {win[6:0], data};
                r_done = !mute && $urandom_range(7) == 0;
                if (!mute && win[7:4] == PAT) begin
                    cnt = (int'(win[3:0]) + 1) * scale;
                    st = 1; counting = 1'b1; win = 8'd0; r_done = 1'b0;
                end
            end else if (st == 1) begin
                if (cnt == 0) begin r_done = 1'b1; counting = 1'b0; st = 2; end
                else cnt = cnt - 1;
            end else if (ack) begin
                r_done = 1'b0; st = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic linger(input int n, input bit junk);
        repeat (n) begin
            start = junk && busy === 1'b1 && $urandom_range(3) == 0;
            delay = 4'hF;
            cyc(1);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit junk);
        int g = 0;
        while (busy !== 1'b0 && g < 20000) begin linger(1, junk); g++; end
        if (busy !== 1'b0) check("wait_idle_bound", busy, 32'd0);
    endtask

    task automatic send(input logic [3:0] d);
        wait_idle(1'b0);
        if (busy !== 1'b0) return;
        start = 1'b1;
        delay = d;
        exp_q.push_back({PAT, d});
        cyc(1);
        start = 1'b0;
        delay = 4'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        cyc(2);
        check("rst_data", data, 32'd0);
        check("rst_ack", ack, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_busy_cnt", busy_cnt, 32'd0);
        check("rst_cmd_done", cmd_done, 32'd0);
        check("rst_err", err, 32'd0);
        reset = 1'b1;
        linger(20, 1'b0);
        scale = 0;
        send(4'b0101);
        wait_idle(1'b0);
        scale = 1000;
        send(4'h0);
        wait_idle(1'b0);
        scale = 2;
        send(4'h3);
        linger(30, 1'b1);
        wait_idle(1'b1);
        repeat (20) begin
            scale = $urandom_range(2);
            send(4'($urandom));
            if ($urandom_range(1) == 1) linger($urandom_range(12), 1'b1);
        end
        wait_idle(1'b1);
        scale = 0;
        send(4'hA);
        cyc(6);
        #2 reset = 1'b0;
        #1;
        check("midrst_data", data, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_ack", ack, 32'd0);
        exp_q.delete();
        cyc(2);
        reset = 1'b1;
        cyc(2);
        send(4'h6);
        wait_idle(1'b0);
        mute = 1'b1;
        send(4'h9);
        cyc(8 + TO + 4);
`ifdef TIMER_TX_TIMEOUT_EN
        check("timeout_busy", busy, 32'd0);
        check("timeout_err", err, 32'd1);
        mute = 1'b0;
        send(4'h1);
        wait_idle(1'b0);
        check("err_sticky", err, 32'd1);
`else
        check("no_timeout_busy", busy, 32'd1);
        check("no_timeout_err", err, 32'd0);
        s_done = 1'b1;
        cyc(1);
        s_done = 1'b0;
        mute = 1'b0;
        wait_idle(1'b0);
`endif
        linger(10, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
